// File: rtl/register_window_controller_if.sv
// Bundle of pipeline, register-file and data-memory signals around the
// register window controller. The controller uses the master modport; the
// surrounding pipeline/register file/memory use the slave modport.
interface register_window_controller_if #(
    parameter int NWIN = 8
);
    localparam int CW = $clog2(NWIN);

    logic            Save;
    logic            Restore;
    logic            Busy;
    logic            Illegal;
    logic [CW-1:0]   CWP;
    logic [NWIN-1:0] WIM;
    logic [NWIN-1:0] WinEn;
    logic [CW-1:0]   RfWin;
    logic [4:0]      RfAddr;
    logic [31:0]     RfRdData;
    logic [31:0]     RfWrData;
    logic            RfWE;
    logic            MemReq;
    logic            MemWr;
    logic [31:0]     MemAddr;
    logic [31:0]     MemWData;
    logic [31:0]     MemRData;
    logic            MemAck;
    logic [15:0]     SpillCnt;
    logic [15:0]     FillCnt;

    modport master (
        input  Save, Restore, RfRdData, MemRData, MemAck,
        output Busy, Illegal, CWP, WIM, WinEn, RfWin, RfAddr, RfWrData, RfWE,
               MemReq, MemWr, MemAddr, MemWData, SpillCnt, FillCnt
    );

    modport slave (
        output Save, Restore, RfRdData, MemRData, MemAck,
        input  Busy, Illegal, CWP, WIM, WinEn, RfWin, RfAddr, RfWrData, RfWE,
               MemReq, MemWr, MemAddr, MemWData, SpillCnt, FillCnt
    );
endinterface

// File: rtl/register_window_controller.sv
// SPARC-style register window controller: tracks CWP/WIM/spill pointer and
// spills or refills the locals+ins (regs 16..31) of a window on overflow or
// underflow. Optional spill/fill counters are built when the macro
// RWC_PERF_CNT_EN is defined; otherwise SpillCnt/FillCnt are tied to zero.
module register_window_controller #(
    parameter int          NWIN       = 8,
    parameter logic [31:0] SPILL_BASE = 32'h0000_F000
) (
    input logic                          Clk,
    input logic                          RstN,
    register_window_controller_if.master bus
);
    localparam int CW = $clog2(NWIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cwp, next_cwp;
    logic [NWIN-1:0] wim, next_wim;
    logic [31:0]     spill_ptr, next_ptr;
    logic [3:0]      idx, next_idx;
    logic [CW-1:0]   rf_win, next_rf_win;
    logic            illegal, next_illegal;
    logic [CW-1:0]   vs, vr, vs2, vr2;
    logic [31:0]     word_offset;
    logic            last_ack;

    // Window arithmetic wraps naturally because the indices are CW bits wide.
    assign vs  = cwp - CW'(1);
    assign vr  = cwp + CW'(1);
    assign vs2 = cwp - CW'(2);
    assign vr2 = cwp + CW'(2);
    assign word_offset = {26'd0, idx, 2'b00};
    assign last_ack = bus.MemAck && (idx == 4'd15);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state     <= IDLE;
            cwp       <= '0;
            wim       <= NWIN'(2);
            spill_ptr <= SPILL_BASE;
            idx       <= '0;
            rf_win    <= '0;
            illegal   <= 1'b0;
        end else begin
            state     <= next_state;
            cwp       <= next_cwp;
            wim       <= next_wim;
            spill_ptr <= next_ptr;
            idx       <= next_idx;
            rf_win    <= next_rf_win;
            illegal   <= next_illegal;
        end
    end

    // Next-state decode and spill/fill datapath outputs.
    always_comb begin
        next_state   = state;
        next_cwp     = cwp;
        next_wim     = wim;
        next_ptr     = spill_ptr;
        next_idx     = idx;
        next_rf_win  = rf_win;
        next_illegal = 1'b0;

        bus.Busy     = 1'b0;
        bus.MemReq   = 1'b0;
        bus.MemWr    = 1'b0;
        bus.MemAddr  = '0;
        bus.MemWData = '0;
        bus.RfWE     = 1'b0;
        bus.RfWrData = '0;

        case (state)
            IDLE: begin
                if (bus.Save && bus.Restore) begin
                    next_illegal = 1'b1;
                end else if (bus.Save) begin
                    if (wim[vs]) begin
                        next_state  = SPILL;
                        next_rf_win = vs;
                        next_idx    = '0;
                    end else begin
                        next_cwp = vs;
                    end
                end else if (bus.Restore) begin
                    if (wim[vr]) begin
                        next_state  = FILL;
                        next_rf_win = vr;
                        next_idx    = '0;
                    end else begin
                        next_cwp = vr;
                    end
                end
            end
            SPILL: begin
                bus.Busy     = 1'b1;
                bus.MemReq   = 1'b1;
                bus.MemWr    = 1'b1;
                bus.MemAddr  = spill_ptr - 32'd64 + word_offset;
                bus.MemWData = bus.RfRdData;
                if (bus.MemAck) begin
                    next_idx = idx + 4'd1;
                end
                if (last_ack) begin
                    next_ptr      = spill_ptr - 32'd64;
                    next_wim[vs]  = 1'b0;
                    next_wim[vs2] = 1'b1;
                    next_cwp      = vs;
                    next_state    = IDLE;
                end
            end
            FILL: begin
                bus.Busy    = 1'b1;
                bus.MemReq  = 1'b1;
                bus.MemAddr = spill_ptr + word_offset;
                if (bus.MemAck) begin
                    bus.RfWE     = 1'b1;
                    bus.RfWrData = bus.MemRData;
                    next_idx     = idx + 4'd1;
                end
                if (last_ack) begin
                    next_ptr      = spill_ptr + 32'd64;
                    next_wim[vr]  = 1'b0;
                    next_wim[vr2] = 1'b1;
                    next_cwp      = vr;
                    next_state    = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Architectural views; the register file sees no window enabled while stalled.
    always_comb begin
        bus.CWP     = cwp;
        bus.WIM     = wim;
        bus.RfWin   = rf_win;
        bus.RfAddr  = {1'b1, idx};
        bus.Illegal = illegal;
        bus.WinEn   = (state == IDLE) ? (NWIN'(1) << cwp) : '0;
    end

`ifdef RWC_PERF_CNT_EN
    logic [15:0] spill_cnt, fill_cnt;

    // Saturating counters of completed spills and fills.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            spill_cnt <= '0;
            fill_cnt  <= '0;
        end else begin
            if (state == SPILL && last_ack && spill_cnt != 16'hFFFF)
                spill_cnt <= spill_cnt + 16'd1;
            if (state == FILL && last_ack && fill_cnt != 16'hFFFF)
                fill_cnt <= fill_cnt + 16'd1;
        end
    end

    assign bus.SpillCnt = spill_cnt;
    assign bus.FillCnt  = fill_cnt;
`else
    assign bus.SpillCnt = '0;
    assign bus.FillCnt  = '0;
`endif
endmodule
